// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared constants and helpers for the BRAM port-B read arbiter
package bram_arb_pkg;

    // Largest supported requester count and BRAM read latency.
    localparam int MAX_NUM_REQ  = 8;
    localparam int MAX_READ_LAT = 3;

    // Width of a requester index at the maximum requester count.
    localparam int MAX_IDX_W = $clog2(MAX_NUM_REQ);

    // One-hot to binary index. OR-reduction form: no priority chain is built,
    // the input is expected to be one-hot or zero (zero yields index 0).
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bram_rd_arbiter_if.sv
// rtl/bram_rd_arbiter_if.sv - requester-side request/response bundle of the BRAM read arbiter
interface bram_rd_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) ();

    // Requester i drives its address in req_addr[i*ADDR_W +: ADDR_W].
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;

    // Response strobe is one-hot; the data word is shared by all requesters.
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    // Requester side.
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/bram_rd_arbiter_rr_pick.sv
// rtl/bram_rd_arbiter_rr_pick.sv - combinational grant picker (round-robin, or fixed priority with BRAM_ARB_FIXED_PRIO_EN)
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
`ifndef BRAM_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] gnt
);

    logic found;

`ifdef BRAM_ARB_FIXED_PRIO_EN

    // Lowest-index valid requester wins; higher indices may starve.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

`else

    // Search starts one past the last winner and wraps; first valid wins.
    // Outer loop walks the search order, inner loop matches the requester
    // at that position so every select index stays a loop constant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && valid[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

`endif

endmodule

// File: rtl/bram_rd_arbiter.sv
// rtl/bram_rd_arbiter.sv - shares BRAM port B among requesters; BRAM_ARB_FIXED_PRIO_EN selects fixed priority
module bram_rd_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    bram_rd_arbiter_if.slave    req_if,
    output logic [ADDR_W-1:0]   bram_addrb,
    output logic                bram_enb,
    input  logic [DATA_W-1:0]   bram_doutb
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_num_req_range
        $error("bram_rd_arbiter: NUM_REQ must be 2..%0d", MAX_NUM_REQ);
    end
    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_read_lat_range
        $error("bram_rd_arbiter: READ_LAT must be 1..%0d", MAX_READ_LAT);
    end

    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [ADDR_W-1:0]  gnt_addr;

    // One-hot owner tag per outstanding read; stage READ_LAT lines up with
    // the cycle bram_doutb carries that read's data.
    logic [NUM_REQ-1:0] tag_q [READ_LAT+1];

`ifdef BRAM_ARB_FIXED_PRIO_EN

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (req_if.req_valid),
        .gnt   (pick_gnt)
    );

`else

    logic [IDX_W-1:0]       last_gnt;
    logic [MAX_NUM_REQ-1:0] gnt_ext;

    assign gnt_ext = MAX_NUM_REQ'(gnt);

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (req_if.req_valid),
        .ptr   (last_gnt),
        .gnt   (pick_gnt)
    );

    // Round-robin pointer moves to the winner only in cycles with a grant;
    // reset value makes requester 0 the first to be searched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= IDX_W'(NUM_REQ - 1);
        end else if (gnt_any) begin
            last_gnt <= IDX_W'(onehot_to_idx(gnt_ext));
        end
    end

`endif

    // No grant is offered while reset is held; picker already never grants
    // a requester without valid.
    assign gnt              = rst ? '0 : pick_gnt;
    assign gnt_any          = |gnt;
    assign req_if.req_ready = gnt;

    // Winner's address; grant is one-hot so an OR of masked lanes suffices.
    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_addr = gnt_addr | req_if.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Issue register: enable follows the grant, address holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addrb <= '0;
            bram_enb   <= 1'b0;
        end else begin
            bram_enb <= gnt_any;
            if (gnt_any) begin
                bram_addrb <= gnt_addr;
            end
        end
    end

    // Tag shift pipeline; a zero tag enters on idle cycles, reset drops all
    // in-flight tags so dropped reads never produce a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= READ_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= gnt;
            for (int s = 1; s <= READ_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign req_if.rsp_valid = tag_q[READ_LAT];
    assign req_if.rsp_data  = bram_doutb;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// tb/tb_bram_rd_arbiter.sv - scoreboard bench for bram_rd_arbiter (READ_LAT 1 and 3 instances)
module tb_bram_rd_arbiter;

    localparam int NR   = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk;
    logic rst;

    bram_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) if0 ();
    bram_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) if1 ();

    logic [AW-1:0] addrb0, addrb1;
    logic          enb0, enb1;
    logic [DW-1:0] dout0, dout1;

    bram_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_if     (if0),
        .bram_addrb (addrb0),
        .bram_enb   (enb0),
        .bram_doutb (dout0)
    );

    bram_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_if     (if1),
        .bram_addrb (addrb1),
        .bram_enb   (enb1),
        .bram_doutb (dout1)
    );

    // Stimulus per DUT
    logic [NR-1:0] v [2];
    logic [AW-1:0] a [2][NR];

    assign if0.req_valid = v[0];
    assign if0.req_addr  = {a[0][2], a[0][1], a[0][0]};
    assign if1.req_valid = v[1];
    assign if1.req_addr  = {a[1][2], a[1][1], a[1][0]};

    // Observation taps
    logic [NR-1:0] o_rdy [2];
    logic [NR-1:0] o_rv  [2];
    logic [DW-1:0] o_rd  [2];
    logic [AW-1:0] o_ab  [2];
    logic          o_en  [2];

    assign o_rdy[0] = if0.req_ready;
    assign o_rdy[1] = if1.req_ready;
    assign o_rv[0]  = if0.rsp_valid;
    assign o_rv[1]  = if1.rsp_valid;
    assign o_rd[0]  = if0.rsp_data;
    assign o_rd[1]  = if1.rsp_data;
    assign o_ab[0]  = addrb0;
    assign o_ab[1]  = addrb1;
    assign o_en[0]  = enb0;
    assign o_en[1]  = enb1;

    // BRAM content model
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] ad);
        return {ad[7:0], ~ad[15:8]} ^ 16'h3c5a;
    endfunction

    logic [DW-1:0] m0;
    logic [DW-1:0] m1 [3];

    always_ff @(posedge clk) begin
        if (enb0) m0 <= mem_word(addrb0);
        if (enb1) m1[0] <= mem_word(addrb1);
        m1[1] <= m1[0];
        m1[2] <= m1[1];
    end

    assign dout0 = m0;
    assign dout1 = m1[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and reference state
    exp_t          sbq [2][$];
    int            mptr [2];
    int            gnt_m [2];
    logic          exp_enb [2];
    logic [AW-1:0] exp_ab [2];
    logic [NR-1:0] seen_rdy [2];
    int            cyc;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] vv, input int ptr);
`ifdef BRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) begin
            if (vv[i]) return i;
        end
`else
        for (int k = 1; k <= NR; k++) begin
            if (vv[(ptr + k) % NR]) return (ptr + k) % NR;
        end
`endif
        return -1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            mptr[d]    = NR - 1;
            gnt_m[d]   = -1;
            exp_enb[d] = 1'b0;
            exp_ab[d]  = '0;
        end
    endtask

    // One clock cycle: check registered outputs and responses, then the
    // combinational grant against the reference, then advance.
    task automatic step();
        exp_t e;
        int   g;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_bram_enb", d), 64'(o_en[d]), 64'(exp_enb[d]));
            check($sformatf("d%0d_bram_addrb", d), 64'(o_ab[d]), 64'(exp_ab[d]));
            if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
                e = sbq[d].pop_front();
                check($sformatf("d%0d_rsp_valid", d), 64'(o_rv[d]), 64'(1) << e.idx);
                check($sformatf("d%0d_rsp_data", d), 64'(o_rd[d]), 64'(e.data));
            end else begin
                check($sformatf("d%0d_rsp_idle", d), 64'(o_rv[d]), 64'(0));
            end
            g = rst ? -1 : model_pick(v[d], mptr[d]);
            gnt_m[d]    = g;
            seen_rdy[d] = o_rdy[d];
            check($sformatf("d%0d_req_ready", d), 64'(o_rdy[d]), (g < 0) ? 64'(0) : (64'(1) << g));
            if (g >= 0) begin
                e.idx  = g;
                e.data = mem_word(a[d][g]);
                e.due  = cyc + 1 + lat_of(d);
                sbq[d].push_back(e);
                mptr[d]    = g;
                exp_enb[d] = 1'b1;
                exp_ab[d]  = a[d][g];
            end else begin
                exp_enb[d] = 1'b0;
                if (rst) exp_ab[d] = '0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_all(input logic [NR-1:0] vv);
        for (int d = 0; d < 2; d++) v[d] = vv;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v[d] = '0;
            for (int r = 0; r < NR; r++) a[d][r] = '0;
        end
        model_reset();

        // Reset state with all requesters asking: no ready, outputs cleared
        #1;
        rst = 1'b1;
        set_all(3'b111);
        step();
        step();
        rst = 1'b0;
        set_all(3'b000);
        step();

        // Single requester streaming addresses 0..15
        set_all(3'b001);
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 2; d++) a[d][0] = AW'(i);
            step();
        end

        // Contention between req0 (0x10) and req1 (0x20)
        for (int d = 0; d < 2; d++) begin
            a[d][0] = 16'h0010;
            a[d][1] = 16'h0020;
        end
        set_all(3'b011);
        for (int i = 0; i < 8; i++) step();

        // Reset mid-burst with reads in flight; nothing may come out after
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        set_all(3'b000);
        for (int i = 0; i < 5; i++) step();

        // Pointer wrap from reset: three requesters all valid
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NR; r++) a[d][r] = AW'(16'h0100 + r);
        end
        set_all(3'b111);
        for (int k = 0; k < 6; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                check($sformatf("d%0d_wrap_order%0d", d, k), 64'(seen_rdy[d]), 64'(1));
`else
                check($sformatf("d%0d_wrap_order%0d", d, k), 64'(seen_rdy[d]), 64'(1) << (k % 3));
`endif
            end
        end

        // Random requests at ~30%, holding until granted
        set_all(3'b000);
        for (int c = 0; c < 300; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < NR; r++) begin
                    if (!v[d][r] || gnt_m[d] == r) begin
                        v[d][r] = ($urandom_range(99) < 30);
                        a[d][r] = AW'($urandom_range(65535));
                    end
                end
            end
            step();
        end

        // Drain and confirm every issued read was answered
        set_all(3'b000);
        for (int i = 0; i < 8; i++) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_sb_empty", d), 64'(sbq[d].size()), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Shares the single read port (port B) of the pattern BRAM among several requesters, such as the LED driver and a debug/readback client. Each requester issues read addresses through a valid/ready handshake. The block grants one requester per cycle using round-robin order and drives `bram_addrb`/`bram_enb`. It routes each returned `bram_doutb` word back to the requester that issued it, using a fixed-latency tag pipeline.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8)
- `ADDR_W`, 16: BRAM address width
- `DATA_W`, 16: BRAM data width
- `READ_LAT`, 1: BRAM read latency in cycles, from the address registered at the port to `bram_doutb` valid (1..3)

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester read request.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; requester i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_ready` out NUM_REQ: combinational grant, one-hot or zero.
- `rsp_valid` out NUM_REQ: registered, one-hot or zero; marks read data for requester i.
- `rsp_data` out DATA_W: broadcast to all requesters; equals `bram_doutb`.
- `bram_addrb` out ADDR_W: registered BRAM port-B address.
- `bram_enb` out 1: registered BRAM port-B enable.
- `bram_doutb` in DATA_W: BRAM port-B read data.

## Operation
- **Handshake.** A transfer occurs in a cycle where `req_valid[i] && req_ready[i]`.
  - Requesters hold `valid` and `addr` stable until `ready`.
  - The block never asserts `ready` without `valid`.
- **Arbitration.** Round-robin pointer `last_gnt`.
  - The search starts at `last_gnt+1` and wraps modulo NUM_REQ; the first valid requester wins.
  - `last_gnt` updates only in cycles with a grant.
  - Reset value is NUM_REQ-1, so requester 0 has first priority.
- **Issue.** On a grant, at the next edge:
  - `bram_addrb` takes the winner's address.
  - `bram_enb` goes to 1.
  - The winner's one-hot tag enters stage 0 of the tag pipeline.
- **No grant.** On a cycle with no grant:
  - `bram_enb` goes to 0.
  - `bram_addrb` holds its previous value.
  - A zero tag enters the pipeline.
- **Response.** `rsp_valid` equals the tag at stage READ_LAT of the pipeline (depth READ_LAT+1). `rsp_data = bram_doutb`.
- **Backpressure.** Responses have no backpressure; requesters must accept `rsp_valid` in the cycle it is asserted.
- **Throughput.** One grant per cycle sustained. Back-to-back grants to the same requester are allowed when it is the only one valid.
- **Reset.**
  - Clears `bram_addrb` (0), `bram_enb` (0), `rsp_valid` (0), all tags (0) and `last_gnt` (NUM_REQ-1).
  - `req_ready` is 0 while `rst` is asserted.
  - In-flight reads are dropped and produce no `rsp_valid`, including after reset releases.

## Timing
- **Latency.** Handshake in cycle t gives `bram_addrb`/`bram_enb` valid in t+1 and `rsp_valid` in t+1+READ_LAT. With READ_LAT=1, the response arrives 2 cycles after the handshake.
- **Response order.** Responses return in issue order with no reordering; responses to the same requester never overlap.
- **Ready path.** `req_ready` depends combinationally on `req_valid` and `last_gnt` only. There is no path from `bram_doutb` to `req_ready`.
- **Simultaneous requests.** All valid requesters in one cycle: exactly one is granted and the others wait. Under full contention, a waiting requester is granted within NUM_REQ-1 cycles.
- **Withdrawn requests.** A requester dropping `valid` without `ready` is legal; nothing is issued for it.

## Configuration
- `BRAM_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority. The lowest-index valid requester always wins, `last_gnt` is not implemented, and starvation of higher indices is permitted.
  - **Undefined (default):** round-robin as specified above.

## Structure
- **Package `bram_arb_pkg`:**
  - Range-check constants `MAX_NUM_REQ=8` and `MAX_READ_LAT=3`.
  - A function for a one-hot to index conversion.
- **Sub-module `rr_pick`:** combinational; takes the valid vector and pointer, returns a one-hot grant. The macro selects the fixed-priority variant inside it.
- **Top level:** handles issue registers and the tag shift pipeline.

## Test plan
- **Reset:** assert `rst` mid-burst with 2 reads in flight → `rsp_valid`=0, `bram_enb`=0, `bram_addrb`=0; no stray responses after release.
- **Single requester:** req0 streams addrs 0..15 continuously → `req_ready[0]`=1 every cycle; `rsp_valid[0]` appears 2 cycles after each handshake; `rsp_data` matches BRAM contents 0..15 in order.
- **Contention:** both valid every cycle, req0 addr 0x10, req1 addr 0x20.
  - Round-robin: grants alternate 0,1,0,1.
  - `BRAM_ARB_FIXED_PRIO_EN` defined: req0 granted every cycle and req1 never granted.
- **Pointer wrap:** NUM_REQ=3, all three valid for 6 cycles → grant order 0,1,2,0,1,2.
- **Idle gaps:** random valid at 30% → `bram_enb` low exactly on non-grant cycles; every handshake yields exactly one `rsp_valid` to the correct index with correct data.
- **Latency parameter:** READ_LAT=3 → `rsp_valid` 4 cycles after the handshake; data correct under random contention.
